zbuf_pixel_writer: RTL and testbench



---
 rtl/zbuf_pixel_writer.sv | 200 ++++++++++++++++++++
 tb/tb_zbuf_pixel_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zbuf_pixel_writer.sv
// Rasterizer plot consumer: FIFO-buffered pixels, depth read-compare-write, full buffer clear.
// One in-range pixel every 4 cycles (IDLE->RD->CMP->WR); every SRAM strobe is registered.
module zbuf_pixel_writer #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          ADDR_W     = 19,
  parameter int          COLOR_W    = 8,
  parameter logic [15:0] Z_CLEAR    = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               plot,
  input  logic [10:0]        x,
  input  logic [10:0]        y,
  input  logic [15:0]        z_in,
  input  logic [COLOR_W-1:0] color,
  input  logic               clear,
  output logic [ADDR_W-1:0]  zb_addr,
  output logic               zb_rd,
  input  logic [15:0]        zb_rdata,
  output logic               zb_wr,
  output logic [15:0]        zb_wdata,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic               fb_wr,
  output logic [COLOR_W-1:0] fb_wdata,
  output logic               busy,
  output logic               overflow,
  output logic               clear_done
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [31:0]       H_LIM     = 32'(H_RES);
  localparam logic [31:0]       V_LIM     = 32'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES*V_RES-1);

  typedef struct packed {
    logic [10:0]        x;
    logic [10:0]        y;
    logic [15:0]        z;
    logic [COLOR_W-1:0] c;
  } entry_t;

  typedef enum logic [2:0] {IDLE, RD, CMP, WR, CLR} state_t;

  entry_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               overflow_q;
  logic               fifo_empty, fifo_full, pop, push_ok;
  entry_t             head;
  logic               head_in_range;
  logic [ADDR_W-1:0]  head_addr;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  zb_addr_q, zb_addr_d, fb_addr_q, fb_addr_d;
  logic               zb_rd_q, zb_rd_d, zb_wr_q, zb_wr_d, fb_wr_q, fb_wr_d;
  logic [15:0]        zb_wdata_q, zb_wdata_d, pix_z_q, pix_z_d;
  logic [COLOR_W-1:0] fb_wdata_q, fb_wdata_d, pix_c_q, pix_c_d;
  logic               clear_pend_q, clear_pend_d, clear_done_q, clear_done_d;

  assign fifo_empty    = (count_q == '0);
  assign fifo_full     = (count_q == FULL_CNT);
  assign push_ok       = plot & (~fifo_full | pop);
  assign head          = fifo_q[rd_ptr_q];
  assign head_in_range = (32'(head.x) < H_LIM) && (32'(head.y) < V_LIM);
  assign head_addr     = ADDR_W'(32'(head.y) * 32'(H_RES) + 32'(head.x));

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= '{x: x, y: y, z: z_in, c: color};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      if (plot && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    zb_addr_d    = zb_addr_q;
    fb_addr_d    = fb_addr_q;
    zb_rd_d      = 1'b0;
    zb_wr_d      = 1'b0;
    fb_wr_d      = 1'b0;
    zb_wdata_d   = zb_wdata_q;
    fb_wdata_d   = fb_wdata_q;
    pix_z_d      = pix_z_q;
    pix_c_d      = pix_c_q;
    clear_done_d = 1'b0;
    // A clear request arriving while a clear is already running is ignored.
    clear_pend_d = clear_pend_q | (clear & (state_q != CLR));
    case (state_q)
      IDLE: begin
        if (clear_pend_q && fifo_empty) begin
          state_d    = CLR;
          zb_addr_d  = '0;
          fb_addr_d  = '0;
          zb_wr_d    = 1'b1;
          fb_wr_d    = 1'b1;
          zb_wdata_d = Z_CLEAR;
          fb_wdata_d = '0;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (head_in_range) begin
            pix_z_d   = head.z;
            pix_c_d   = head.c;
            zb_addr_d = head_addr;
            zb_rd_d   = 1'b1;
            state_d   = RD;
          end
        end
      end
      RD:  state_d = CMP;
      CMP: begin
        // Strict compare: on equal depth the fragment already stored wins.
        if (pix_z_q < zb_rdata) begin
          zb_wr_d    = 1'b1;
          zb_wdata_d = pix_z_q;
          fb_wr_d    = 1'b1;
          fb_addr_d  = zb_addr_q;
          fb_wdata_d = pix_c_q;
        end
        state_d = WR;
      end
      WR:  state_d = IDLE;
      CLR: begin
        if (zb_addr_q == LAST_ADDR) begin
          clear_done_d = 1'b1;
          clear_pend_d = 1'b0;
          state_d      = IDLE;
        end else begin
          zb_addr_d  = zb_addr_q + ADDR_W'(1);
          fb_addr_d  = zb_addr_q + ADDR_W'(1);
          zb_wr_d    = 1'b1;
          fb_wr_d    = 1'b1;
          zb_wdata_d = Z_CLEAR;
          fb_wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      zb_addr_q    <= '0;
      fb_addr_q    <= '0;
      zb_rd_q      <= 1'b0;
      zb_wr_q      <= 1'b0;
      fb_wr_q      <= 1'b0;
      zb_wdata_q   <= '0;
      fb_wdata_q   <= '0;
      pix_z_q      <= '0;
      pix_c_q      <= '0;
      clear_pend_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      zb_addr_q    <= zb_addr_d;
      fb_addr_q    <= fb_addr_d;
      zb_rd_q      <= zb_rd_d;
      zb_wr_q      <= zb_wr_d;
      fb_wr_q      <= fb_wr_d;
      zb_wdata_q   <= zb_wdata_d;
      fb_wdata_q   <= fb_wdata_d;
      pix_z_q      <= pix_z_d;
      pix_c_q      <= pix_c_d;
      clear_pend_q <= clear_pend_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign zb_addr    = zb_addr_q;
  assign zb_rd      = zb_rd_q;
  assign zb_wr      = zb_wr_q;
  assign zb_wdata   = zb_wdata_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wr      = fb_wr_q;
  assign fb_wdata   = fb_wdata_q;
  assign overflow   = overflow_q;
  assign clear_done = clear_done_q;
  assign busy       = ~fifo_empty | (state_q != IDLE) | clear_pend_q;

endmodule

// File: tb/tb_zbuf_pixel_writer.sv
// Bench for zbuf_pixel_writer on an 8x4 screen: SRAM models, a queue-based reference model
// run in lockstep, a directed vector table, burst/reset sequences and randomized plots.
module tb_zbuf_pixel_writer;
  localparam int          FD = 8, HR = 8, VR = 4, AW = 19, CW = 8, NPIX = HR * VR;
  localparam logic [15:0] ZC = 16'hFFFF;

  typedef struct packed {logic [10:0] x; logic [10:0] y; logic [15:0] z; logic [7:0] c;} pix_t;
  typedef struct packed {logic [4:0] a; logic [15:0] z; logic [7:0] c;} wr_t;
  typedef struct {logic [10:0] x; logic [10:0] y; logic [15:0] z; logic [7:0] c; bit rd; bit wr; int addr;} vec_t;

  logic          clk = 0, reset = 1, plot = 0, clear = 0;
  logic [10:0]   x = 0, y = 0;
  logic [15:0]   z_in = 0, zb_rdata = 0, zb_wdata;
  logic [CW-1:0] color = 0, fb_wdata;
  logic [AW-1:0] zb_addr, fb_addr;
  logic          zb_rd, zb_wr, fb_wr, busy, overflow, clear_done;

  int n_vec = 0, n_bad = 0, done_cnt = 0, rd_cnt = 0;

  zbuf_pixel_writer #(.FIFO_DEPTH(FD), .H_RES(HR), .V_RES(VR), .ADDR_W(AW), .COLOR_W(CW), .Z_CLEAR(ZC)) dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .z_in(z_in), .color(color), .clear(clear),
    .zb_addr(zb_addr), .zb_rd(zb_rd), .zb_rdata(zb_rdata), .zb_wr(zb_wr), .zb_wdata(zb_wdata),
    .fb_addr(fb_addr), .fb_wr(fb_wr), .fb_wdata(fb_wdata), .busy(busy), .overflow(overflow),
    .clear_done(clear_done));

  always #5 clk = ~clk;

  logic [15:0] dmem [NPIX];
  logic [7:0]  fmem [NPIX];
  always @(posedge clk) begin
    if (zb_rd) zb_rdata <= dmem[zb_addr[4:0]];
    if (zb_wr) dmem[zb_addr[4:0]] <= zb_wdata;
    if (fb_wr) fmem[fb_addr[4:0]] <= fb_wdata;
  end

  wr_t obs_q[$], exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (clear_done) done_cnt++;
    if (zb_rd) rd_cnt++;
    if (zb_wr || fb_wr) begin
      chk("strobe_pair", {zb_wr, fb_wr, zb_rd, 32'(zb_addr == fb_addr)}, {1'b1, 1'b1, 1'b0, 32'd1});
      if (fb_wr) begin
        w = {fb_addr[4:0], zb_wdata, fb_wdata};
        obs_q.push_back(w);
      end
    end
  end

  // Reference model: FIFO as a queue, engine as a "cycles until free" counter, depth as an array.
  pix_t        mq[$];
  pix_t        m_cur;
  int          m_busy = 0, m_rd_addr = 0, m_rd_total = 0;
  bit          m_clearing = 0, m_pend = 0, m_ovf = 0, m_cur_vld = 0, m_rd_exp = 0, m_done_exp = 0;
  logic [15:0] mdepth [NPIX];
  logic [7:0]  mfb    [NPIX];

  function automatic bit mbusy();
    return (m_busy > 0) || (mq.size() > 0) || m_pend;
  endfunction

  function automatic pix_t mk(input int px, input int py, input int pz, input int pc);
    return {11'(px), 11'(py), 16'(pz), 8'(pc)};
  endfunction

  task automatic model_edge(input bit p, input pix_t in, input bit clr, input bit rst);
    bit   full, popped, was_clr;
    pix_t h;
    int   a;
    wr_t  w;
    m_rd_exp = 0;
    m_done_exp = 0;
    if (rst) begin
      mq.delete();
      m_busy = 0; m_clearing = 0; m_pend = 0; m_ovf = 0; m_cur_vld = 0;
      return;
    end
    full = (mq.size() == FD);
    was_clr = m_clearing;
    popped = 0;
    if (m_busy == 0) begin
      if (m_pend && mq.size() == 0) begin
        m_clearing = 1;
        m_busy = NPIX;
        for (int i = 0; i < NPIX; i++) begin
          mdepth[i] = ZC;
          mfb[i] = 8'h00;
          w = {5'(i), ZC, 8'h00};
          exp_q.push_back(w);
        end
      end else if (mq.size() != 0) begin
        h = mq.pop_front();
        popped = 1;
        if (h.x < HR && h.y < VR) begin
          m_cur = h; m_cur_vld = 1; m_busy = 3;
          m_rd_exp = 1; m_rd_total++;
          m_rd_addr = int'(h.y) * HR + int'(h.x);
        end
      end
    end else begin
      m_busy--;
      if (m_cur_vld && m_busy == 1) begin
        a = int'(m_cur.y) * HR + int'(m_cur.x);
        if (m_cur.z < mdepth[a]) begin
          mdepth[a] = m_cur.z;
          mfb[a] = m_cur.c;
          w = {5'(a), m_cur.z, m_cur.c};
          exp_q.push_back(w);
        end
        m_cur_vld = 0;
      end
      if (m_clearing && m_busy == 0) begin
        m_clearing = 0; m_pend = 0; m_done_exp = 1;
      end
    end
    if (clr && !was_clr) m_pend = 1;
    if (p) begin
      if (!full || popped) mq.push_back(in);
      else m_ovf = 1;
    end
  endtask

  task automatic cyc(input bit p, input pix_t in, input bit clr, input bit rst);
    plot = p; x = in.x; y = in.y; z_in = in.z; color = in.c; clear = clr; reset = rst;
    @(posedge clk);
    model_edge(p, in, clr, rst);
    #1;
    chk("busy", 32'(busy), 32'(mbusy()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("zb_rd", 32'(zb_rd), 32'(m_rd_exp));
    chk("clear_done", 32'(clear_done), 32'(m_done_exp));
    if (m_rd_exp) chk("rd_addr", 32'(zb_addr), 32'(m_rd_addr));
    plot = 0; clear = 0; reset = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, '0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (busy || mbusy()); i++) idle(1);
    chk("drain", 32'(busy), 32'd0);
    idle(2);
  endtask

  task automatic cmp_logs(input string name);
    int n;
    chk({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(name, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t tv[10];
    bit   p, clr;
    pix_t in;
    tv[0] = '{x: 3, y: 2, z: 100,      c: 8'h5A, rd: 1, wr: 1, addr: 19};
    tv[1] = '{x: 3, y: 2, z: 100,      c: 8'h77, rd: 1, wr: 0, addr: 19};
    tv[2] = '{x: 3, y: 2, z: 99,       c: 8'h33, rd: 1, wr: 1, addr: 19};
    tv[3] = '{x: 0, y: 0, z: 0,        c: 8'h11, rd: 1, wr: 1, addr: 0};
    tv[4] = '{x: 7, y: 3, z: 16'hFFFE, c: 8'h22, rd: 1, wr: 1, addr: 31};
    tv[5] = '{x: 7, y: 3, z: 16'hFFFF, c: 8'h44, rd: 1, wr: 0, addr: 31};
    tv[6] = '{x: 8, y: 0, z: 5,        c: 8'h66, rd: 0, wr: 0, addr: 0};
    tv[7] = '{x: 0, y: 4, z: 5,        c: 8'h66, rd: 0, wr: 0, addr: 0};
    tv[8] = '{x: 0, y: 0, z: 0,        c: 8'h99, rd: 1, wr: 0, addr: 0};
    tv[9] = '{x: 7, y: 0, z: 16'hFFFF, c: 8'h01, rd: 1, wr: 0, addr: 7};
    for (int i = 0; i < NPIX; i++) begin
      dmem[i] = 16'h0; fmem[i] = 8'h0; mdepth[i] = 16'h0; mfb[i] = 8'h0;
    end

    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    chk("rst_strobes", {26'd0, zb_rd, zb_wr, fb_wr, busy, overflow, clear_done}, 32'd0);
    chk("rst_addr", 32'(zb_addr) | 32'(fb_addr), 32'd0);
    chk("rst_wdata", {8'd0, zb_wdata, fb_wdata}, 32'd0);

    cyc(0, '0, 1, 0);
    drain();
    cmp_logs("clear_log");
    chk("clear_done_cnt", 32'(done_cnt), 32'd1);

    foreach (tv[i]) begin
      cyc(1, mk(tv[i].x, tv[i].y, tv[i].z, tv[i].c), 0, 0);
      idle(1);
      chk("tv_rd", 32'(zb_rd), 32'(tv[i].rd));
      idle(2);
      chk("tv_wr", {30'd0, zb_wr, fb_wr}, {30'd0, tv[i].wr, tv[i].wr});
      if (tv[i].wr) begin
        chk("tv_addr", 32'(fb_addr), 32'(tv[i].addr));
        chk("tv_wdata", {8'd0, zb_wdata, fb_wdata}, {8'd0, tv[i].z, tv[i].c});
      end
      idle(1);
    end
    chk("tv_busy_end", 32'(busy), 32'd0);
    chk("tv_no_ovf", 32'(overflow), 32'd0);
    cmp_logs("table_log");

    rd_cnt = 0;
    m_rd_total = 0;
    for (int i = 0; i < 12; i++) cyc(1, mk(i % 8, 1 + i / 8, 1000 - i, i + 1), 0, 0);
    drain();
    chk("burst_ovf", 32'(overflow), 32'd1);
    chk("burst_accepted", 32'(rd_cnt), 32'(m_rd_total));
    cmp_logs("burst_log");

    cyc(1, mk(1, 1, 5, 8'hAB), 0, 0);
    idle(1);
    cyc(0, '0, 0, 1);
    chk("midrst_strobes", {26'd0, zb_rd, zb_wr, fb_wr, busy, overflow, clear_done}, 32'd0);
    chk("midrst_addr", 32'(zb_addr) | 32'(fb_addr), 32'd0);
    chk("midrst_wdata", {8'd0, zb_wdata, fb_wdata}, 32'd0);
    idle(4);
    cmp_logs("midrst_log");
    cyc(1, mk(1, 1, 5, 8'hAB), 0, 0);
    idle(5);
    cmp_logs("postrst_log");

    cyc(0, '0, 1, 0);
    drain();
    for (int i = 0; i < 400; i++) begin
      p   = ($urandom_range(0, 2) == 0);
      in  = mk($urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 400), $urandom_range(0, 255));
      clr = ($urandom_range(0, 99) == 0);
      cyc(p, in, clr, 0);
    end
    drain();
    cmp_logs("rand_log");
    for (int i = 0; i < NPIX; i++) begin
      chk("final_depth", 32'(dmem[i]), 32'(mdepth[i]));
      chk("final_color", 32'(fmem[i]), 32'(mfb[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
